// File: rtl/event_trigger_unit.sv
// Multi-channel event trigger with per-channel delay and a
// round-robin arbitrated single-entry response stage.
module event_trigger_unit #(
   parameter  int NUM_CH  = 4,
   parameter  int DELAY_W = 8,
   parameter  int CNT_W   = 16,
   localparam int CH_W    = $clog2(NUM_CH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_CH-1:0]  trig,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic               cfg_cont,
   output logic               resp_valid,
   output logic [CH_W-1:0]    resp_ch,
   input  logic               resp_ready,
   output logic [NUM_CH-1:0]  busy,
   output logic [NUM_CH-1:0]  overrun,
   output logic [CNT_W-1:0]   resp_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_PEND = 2'd2;

   logic [NUM_CH-1:0][1:0]         state_q, state_d;
   logic [NUM_CH-1:0][DELAY_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0][DELAY_W-1:0] delay_q, delay_d;
   logic [NUM_CH-1:0]              cont_q, cont_d;
   logic [NUM_CH-1:0]              ovr_q, ovr_d;
   logic                           resp_valid_q, resp_valid_d;
   logic [CH_W-1:0]                resp_ch_q, resp_ch_d;
   logic [CH_W-1:0]                ptr_q, ptr_d;
   logic [CNT_W-1:0]               resp_count_q, resp_count_d;

   logic [NUM_CH-1:0] pend;
   logic              gnt_vld;
   logic [CH_W-1:0]   gnt;
   logic [CH_W-1:0]   gnt_nxt;
   logic [CH_W-1:0]   arb_idx;
   logic              load;
   logic              take;
   logic              cfg_ok;

   always_comb begin
      pend = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pend[i] = (state_q[i] == S_PEND);
      end
   end

   // First pending channel at or after the pointer, wrapping.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      arb_idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         arb_idx = CH_W'((32'(ptr_q) + k) % NUM_CH);
         if (!gnt_vld && pend[arb_idx]) begin
            gnt_vld = 1'b1;
            gnt     = arb_idx;
         end
      end
   end

   assign gnt_nxt = (32'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
   assign load    = !resp_valid_q || resp_ready;
   assign take    = load && gnt_vld;
   assign cfg_ok  = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         unique case (state_q[i])
            S_IDLE: begin
               if (enable && (trig[i] || cont_q[i])) begin
                  cnt_d[i]   = delay_q[i];
                  state_d[i] = S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q[i] == '0) begin
                  state_d[i] = S_PEND;
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
            S_PEND: begin
               if (take && gnt == CH_W'(i)) begin
                  state_d[i] = S_IDLE;
               end
            end
            default: state_d[i] = S_IDLE;
         endcase
      end
   end

   // A fresh overrun outranks a same-edge config clear.
   always_comb begin
      delay_d = delay_q;
      cont_d  = cont_q;
      ovr_d   = ovr_q;
      if (cfg_we && cfg_ok) begin
         delay_d[cfg_ch] = cfg_delay;
         cont_d[cfg_ch]  = cfg_cont;
         ovr_d[cfg_ch]   = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (enable && trig[i] && state_q[i] != S_IDLE) begin
            ovr_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_ch_d    = resp_ch_q;
      ptr_d        = ptr_q;
      resp_count_d = resp_count_q;
      if (resp_valid_q && resp_ready) begin
         resp_count_d = resp_count_q + 1'b1;
      end
      if (load) begin
         resp_valid_d = gnt_vld;
         if (gnt_vld) begin
            resp_ch_d = gnt;
            ptr_d     = gnt_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= '0;
         cnt_q        <= '0;
         delay_q      <= '0;
         cont_q       <= '0;
         ovr_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_ch_q    <= '0;
         ptr_q        <= '0;
         resp_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         delay_q      <= delay_d;
         cont_q       <= cont_d;
         ovr_q        <= ovr_d;
         resp_valid_q <= resp_valid_d;
         resp_ch_q    <= resp_ch_d;
         ptr_q        <= ptr_d;
         resp_count_q <= resp_count_d;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (state_q[i] != S_IDLE);
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_ch    = resp_ch_q;
   assign overrun    = ovr_q;
   assign resp_count = resp_count_q;

endmodule

// File: tb/tb_event_trigger_unit.sv
// Scoreboard bench for event_trigger_unit: directed scenarios
// followed by randomized traffic against a due-time model.
module tb_event_trigger_unit;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [3:0]  trig = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [7:0]  cfg_delay = '0;
   logic        cfg_cont = 1'b0;
   logic        resp_ready = 1'b0;
   logic        resp_valid;
   logic [1:0]  resp_ch;
   logic [3:0]  busy;
   logic [3:0]  overrun;
   logic [15:0] resp_count;

   event_trigger_unit dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .trig      (trig),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_delay (cfg_delay),
      .cfg_cont  (cfg_cont),
      .resp_valid(resp_valid),
      .resp_ch   (resp_ch),
      .resp_ready(resp_ready),
      .busy      (busy),
      .overrun   (overrun),
      .resp_count(resp_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Model: a channel is active from trigger until granted, and is
   // pending from edge (trigger_edge + delay + 2) onward.
   int cyc = 0;
   bit m_act[N];
   int m_due[N];
   int m_delay[N];
   bit m_cont[N];
   bit m_ov[N];
   bit m_v;
   int m_ptr;
   int m_cnt;
   int sbq[$];
   bit mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit was[N];
      bit pend[N];
      bit setov[N];
      bit found;
      int g;
      int e;
      e = cyc;
      cyc++;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_due[i] = 0; m_delay[i] = 0;
            m_cont[i] = 0; m_ov[i] = 0;
         end
         m_v = 0; m_ptr = 0; m_cnt = 0;
         sbq.delete();
         return;
      end
      for (int i = 0; i < N; i++) begin
         was[i] = m_act[i];
         pend[i] = m_act[i] && (e > m_due[i]);
      end
      if (m_v && resp_ready) m_cnt = (m_cnt + 1) % 65536;
      if (!m_v || resp_ready) begin
         found = 0;
         g = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && pend[(m_ptr + k) % N]) begin
               found = 1;
               g = (m_ptr + k) % N;
            end
         end
         m_v = found;
         if (found) begin
            m_act[g] = 0;
            m_ptr = (g + 1) % N;
            sbq.push_back(g);
         end
      end
      for (int i = 0; i < N; i++) begin
         setov[i] = was[i] && enable && trig[i];
         if (!was[i] && enable && (trig[i] || m_cont[i])) begin
            m_act[i] = 1;
            m_due[i] = e + m_delay[i] + 1;
         end
      end
      if (cfg_we) begin
         m_delay[cfg_ch] = cfg_delay;
         m_cont[cfg_ch] = cfg_cont;
         m_ov[cfg_ch] = 0;
      end
      for (int i = 0; i < N; i++) if (setov[i]) m_ov[i] = 1;
   endtask

   function automatic logic [3:0] vec_act();
      logic [3:0] v;
      for (int i = 0; i < N; i++) v[i] = m_act[i];
      return v;
   endfunction

   function automatic logic [3:0] vec_ov();
      logic [3:0] v;
      for (int i = 0; i < N; i++) v[i] = m_ov[i];
      return v;
   endfunction

   // Monitor samples late in the low phase, after inputs settle.
   always @(negedge clk) begin
      #3;
      if (mon_en) begin
         chk("busy", busy, vec_act());
         chk("overrun", overrun, vec_ov());
         chk("resp_valid", resp_valid, m_v);
         chk("resp_count", resp_count, m_cnt);
         if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected", 1, 0);
            end else begin
               chk("sb_resp_ch", resp_ch, sbq.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic cfg(input int ch, input int d, input bit c);
      cfg_we = 1; cfg_ch = 2'(ch); cfg_delay = 8'(d); cfg_cont = c;
      tick();
      cfg_we = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      reset = 0;
   endtask

   int got[$];
   int tq[$];
   int n;

   initial begin
      @(negedge clk);
      tick();
      tick();
      reset = 0;
      mon_en = 1;

      // Reset mid-WAIT discards everything.
      enable = 1; resp_ready = 1;
      cfg(1, 5, 0);
      trig = 4'b0010; tick(); trig = 0;
      tick(); tick();
      chk("busy_midwait", busy, 4'b0010);
      do_reset();
      chk("rst_busy", busy, 4'b0000);
      chk("rst_valid", resp_valid, 1'b0);
      chk("rst_count", resp_count, 16'd0);
      chk("rst_ovr", overrun, 4'b0000);
      n = 0;
      repeat (12) begin tick(); if (resp_valid) n++; end
      chk("rst_no_resp", n, 0);

      // One-shot latency: delay 3 -> valid only after edge T+5.
      cfg(2, 3, 0);
      trig = 4'b0100; tick(); trig = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("lat_valid", resp_valid, (k == 5) ? 1 : 0);
         if (k == 5) chk("lat_ch", resp_ch, 2);
      end
      chk("lat_count", resp_count, 1);

      // Round robin from pointer 0, then from pointer 2.
      do_reset();
      for (int c = 0; c < N; c++) cfg(c, 0, 0);
      trig = 4'hF; tick(); trig = 0;
      got.delete();
      repeat (8) begin tick(); if (resp_valid) got.push_back(int'(resp_ch)); end
      chk("rr0_len", got.size(), 4);
      for (int k = 0; k < 4 && k < got.size(); k++) chk("rr0_ch", got[k], k);
      trig = 4'b0010; tick(); trig = 0;
      repeat (4) tick();
      trig = 4'hF; tick(); trig = 0;
      got.delete();
      repeat (8) begin tick(); if (resp_valid) got.push_back(int'(resp_ch)); end
      chk("rr2_len", got.size(), 4);
      for (int k = 0; k < 4 && k < got.size(); k++)
         chk("rr2_ch", got[k], (k + 2) % 4);

      // Backpressure holds the response stable.
      resp_ready = 0;
      trig = 4'b0001; tick(); trig = 0;
      tick(); tick();
      repeat (10) begin
         tick();
         chk("bp_valid", resp_valid, 1);
         chk("bp_ch", resp_ch, 0);
      end
      chk("bp_cnt_before", resp_count, 9);
      resp_ready = 1;
      tick();
      chk("bp_cnt_after", resp_count, 10);
      chk("bp_drained", resp_valid, 0);

      // Overrun: second trigger mid-delay is dropped and flagged.
      cfg(3, 10, 0);
      trig = 4'b1000; tick(); trig = 0;
      repeat (3) tick();
      trig = 4'b1000; tick(); trig = 0;
      chk("ovr_set", overrun[3], 1);
      n = 0;
      repeat (15) begin tick(); if (resp_valid && resp_ch == 2'd3) n++; end
      chk("ovr_single_resp", n, 1);
      cfg(3, 10, 0);
      chk("ovr_cleared", overrun[3], 0);

      // Continuous mode re-fires every delay+3 cycles.
      cfg(1, 2, 1);
      tq.delete();
      for (int k = 0; k < 30; k++) begin
         tick();
         if (resp_valid) tq.push_back(k);
      end
      chk("cont_enough", tq.size() >= 5, 1);
      for (int j = 1; j < tq.size(); j++) chk("cont_period", tq[j] - tq[j-1], 5);
      enable = 0;
      n = 0;
      repeat (15) begin tick(); if (resp_valid) n++; end
      chk("cont_stop", n <= 1, 1);
      chk("cont_idle", busy, 4'b0000);
      cfg(1, 2, 0);
      enable = 1;

      // Counter wrap from a preloaded value.
      force dut.resp_count_q = 16'hFFFD;
      m_cnt = 16'hFFFD;
      #1 release dut.resp_count_q;
      repeat (3) begin
         trig = 4'b0001; tick(); trig = 0;
         tick(); tick(); tick();
      end
      chk("cnt_wrap", resp_count, 16'd0);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         reset = ($urandom_range(199) == 0);
         enable = ($urandom_range(7) != 0);
         for (int i = 0; i < N; i++) trig[i] = ($urandom_range(5) == 0);
         cfg_we = ($urandom_range(9) == 0);
         cfg_ch = 2'($urandom_range(3));
         cfg_delay = 8'($urandom_range(5));
         cfg_cont = ($urandom_range(4) == 0);
         resp_ready = ($urandom_range(3) != 0);
         tick();
      end
      reset = 0; trig = 0; cfg_we = 0; enable = 0; resp_ready = 1;
      repeat (20) tick();
      chk("end_queue_empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
